// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
// Operand widths, FSM states, flag bundle and operand classification.
package fp_mul_pkg;

    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int W          = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int SIG_W      = MANT_WIDTH + 1;
    localparam int PROD_W     = 2 * SIG_W;
    localparam int EXPS_W     = EXP_WIDTH + 2;
    localparam int CNT_W      = $clog2(SIG_W + 1);
    localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN    = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [W-1:0] POS_INF = {1'b0, EXP_ONES, {MANT_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Denormals classify as zero so they take the one-cycle special path.
    function automatic fp_class_t fp_classify(input logic [W-1:0] x);
        fp_class_t c;
        c.nan  = (x[W-2 -: EXP_WIDTH] == EXP_ONES) && (x[MANT_WIDTH-1:0] != '0);
        c.inf  = (x[W-2 -: EXP_WIDTH] == EXP_ONES) && (x[MANT_WIDTH-1:0] == '0);
        c.zero = (x[W-2 -: EXP_WIDTH] == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_normround.sv
// Combinational normalize/round stage: picks the mantissa window, rounds, fixes exponent, overflow/FTZ.
// FP_MUL_RNE_EN selects round-to-nearest-even with a live inexact flag; otherwise truncation.
module fp_mul_normround
    import fp_mul_pkg::*;
(
    input  logic                     sign,
    input  logic signed [EXPS_W-1:0] exp_in,
    input  logic [PROD_W-1:0]        prod,
    output logic [W-1:0]             result,
    output flags_t                   flags
);

`ifdef FP_MUL_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    localparam logic signed [EXPS_W-1:0] EXP_MAX_S = EXPS_W'(2 ** EXP_WIDTH - 1);

    logic                     hi;
    logic [MANT_WIDTH-1:0]    mant;
    logic                     grd, rnd, stk;
    logic                     round_up;
    logic [MANT_WIDTH:0]      mant_r;
    logic signed [EXPS_W-1:0] exp_n, exp_f;

    always_comb begin
        hi = prod[PROD_W-1];
        if (hi) begin
            mant = prod[PROD_W-2 -: MANT_WIDTH];
            grd  = prod[SIG_W-1];
            rnd  = prod[SIG_W-2];
            stk  = |prod[SIG_W-3:0];
        end else begin
            mant = prod[PROD_W-3 -: MANT_WIDTH];
            grd  = prod[SIG_W-2];
            rnd  = prod[SIG_W-3];
            stk  = |prod[SIG_W-4:0];
        end
        exp_n    = exp_in + EXPS_W'(hi);
        round_up = RNE_EN & grd & (rnd | stk | mant[0]);
        mant_r   = {1'b0, mant} + (MANT_WIDTH+1)'(round_up);
        // A rounding carry leaves the stored mantissa at zero; only the exponent moves.
        exp_f    = exp_n + EXPS_W'(mant_r[MANT_WIDTH]);

        flags  = '0;
        result = {sign, exp_f[EXP_WIDTH-1:0], mant_r[MANT_WIDTH-1:0]};
        if (exp_f >= EXP_MAX_S) begin
            result         = {sign, POS_INF[W-2:0]};
            flags.overflow = 1'b1;
            flags.inexact  = RNE_EN;
        end else if (exp_f[EXPS_W-1] || (exp_f == '0)) begin
            result          = {sign, {(W-1){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = RNE_EN;
        end else begin
            flags.inexact = RNE_EN & (grd | rnd | stk);
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: one-cycle special-case path, shift-add mantissa loop, normalize/round.
// Rounding mode selected by FP_MUL_RNE_EN (defined: RNE, undefined: truncation).
//
// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// SPECIAL | resolve NaN/inf/zero/denormal operands
// MUL     | first cycle loads product reg, then one shift-add step per cycle
// NORM    | register normalized/rounded result
// DONE    | out_valid held until out_ready
module fp_mul_seq
    import fp_mul_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_invalid,
    output logic         flag_overflow,
    output logic         flag_underflow,
    output logic         flag_inexact
);

    state_e              state_q, state_d;
    logic [W-1:0]        op1_q, op1_d, op2_q, op2_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        result_q, result_d;
    flags_t              flags_q, flags_d;

    fp_class_t                c_in1, c_in2, c_r1, c_r2;
    logic                     sign_x;
    logic [SIG_W-1:0]         sig1;
    logic [SIG_W:0]           step_sum;
    logic signed [EXPS_W-1:0] exp_sum;
    logic [W-1:0]             nr_result;
    flags_t                   nr_flags;

    assign c_in1  = fp_classify(op1);
    assign c_in2  = fp_classify(op2);
    assign c_r1   = fp_classify(op1_q);
    assign c_r2   = fp_classify(op2_q);
    assign sign_x = op1_q[W-1] ^ op2_q[W-1];
    assign sig1   = {1'b1, op1_q[MANT_WIDTH-1:0]};

    // Multiplier sits in the low half and shifts out; partial sum accumulates in the high half.
    assign step_sum = {1'b0, prod_q[PROD_W-1:SIG_W]} + (prod_q[0] ? {1'b0, sig1} : '0);

    assign exp_sum = $signed(EXPS_W'(op1_q[W-2 -: EXP_WIDTH]))
                   + $signed(EXPS_W'(op2_q[W-2 -: EXP_WIDTH]))
                   - $signed(EXPS_W'(BIAS));

    fp_mul_normround u_normround (
        .sign   (sign_x),
        .exp_in (exp_sum),
        .prod   (prod_q),
        .result (nr_result),
        .flags  (nr_flags)
    );

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    cnt_d   = '0;
                    state_d = (|{c_in1, c_in2}) ? ST_SPECIAL : ST_MUL;
                end
            end
            ST_SPECIAL: begin
                flags_d = '0;
                if (c_r1.nan || c_r2.nan) begin
                    result_d = QNAN;
                end else if ((c_r1.inf && c_r2.zero) || (c_r2.inf && c_r1.zero)) begin
                    result_d        = QNAN;
                    flags_d.invalid = 1'b1;
                end else if (c_r1.inf || c_r2.inf) begin
                    result_d = {sign_x, POS_INF[W-2:0]};
                end else begin
                    result_d = {sign_x, {(W-1){1'b0}}};
                end
                state_d = ST_DONE;
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    prod_d = {{SIG_W{1'b0}}, 1'b1, op2_q[MANT_WIDTH-1:0]};
                end else begin
                    prod_d = {step_sum, prod_q[SIG_W-1:1]};
                end
                if (cnt_q == CNT_W'(SIG_W)) begin
                    cnt_d   = '0;
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NORM: begin
                result_d = nr_result;
                flags_d  = nr_flags;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready       = (state_q == ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign result         = result_q;
    assign flag_invalid   = flags_q.invalid;
    assign flag_overflow  = flags_q.overflow;
    assign flag_underflow = flags_q.underflow;
    assign flag_inexact   = flags_q.inexact;

endmodule
